i8088_bus_master: RTL and testbench
===================================

I8088_BUS_MASTER -- requirements
Module: i8088_bus_master

Interface
REQ-001 Parameter ADDR_W, 20, bus address width.
REQ-002 Parameter DATA_W, 8, bus data width.
REQ-003 Parameter MAX_WAIT, 15, maximum wait states before timeout abort; range 1..255.
REQ-004 CLK  in  1  single clock; all state changes on rising edge.
REQ-005 RESET  in  1  reset, synchronous and active-high.
REQ-006 req_valid  in  1  host request pending.
REQ-007 req_ready  out  1  request accepted on an edge where req_valid&req_ready.
REQ-008 req_write  in  1  1=write cycle, 0=read cycle.
REQ-009 req_iom  in  1  1=memory space, 0=I/O space.
REQ-010 req_addr  in  ADDR_W  target address.
REQ-011 req_wdata  in  DATA_W  write data.
REQ-012 rsp_valid  out  1  one-cycle pulse on bus cycle completion.
REQ-013 rsp_rdata  out  DATA_W  read data; valid with rsp_valid on reads.
REQ-014 rsp_err  out  1  qualifies rsp_valid; 1=timeout abort.
REQ-015 ALE  out  1  address latch enable, active-high.
REQ-016 RD  out  1  read strobe, active-low.
REQ-017 WR  out  1  write strobe, active-low.
REQ-018 IOM  out  1  memory/IO space select for the cycle.
REQ-019 Address  out  ADDR_W  bus address.
REQ-020 Data  inout  DATA_W  bidirectional bus data, tri-stated when not driven.
REQ-021 READY  in  1  peripheral ready; low requests wait states.

Function
REQ-022 FSM states: TI, T1, T2, T3, TW, T4, one-hot encoded.
REQ-023 req_ready=1 only in TI and T4; acceptance latches req_write, req_iom, req_addr, req_wdata, next state T1.
REQ-024 TI or T4 with no acceptance -> TI.
REQ-025 T1: ALE=1; Address and IOM driven from latched request; T1 -> T2 unconditionally.
REQ-026 Address and IOM held stable from T1 through T4 inclusive.
REQ-027 T2: RD=0 for a read, WR=0 for a write; strobe held low through T3 and all TW; T2 -> T3.
REQ-028 Write: Data driven with latched write data from T2 through T4; never driven on reads or in TI.
REQ-029 T3 with READY=1 -> T4; T3 with READY=0 -> TW, wait counter cleared.
REQ-030 TW: counter increments per cycle; READY=1 -> T4; counter reaching MAX_WAIT with READY=0 -> T4 with abort flag set.
REQ-031 Read data captured from Data on the edge leaving T3 or TW with READY=1.
REQ-032 T4: RD=WR=1, ALE=0; rsp_valid=1 for exactly this cycle; rsp_err=abort flag; rsp_rdata holds captured data (all zeros on abort or write).
REQ-033 Minimum cycle 4 clocks (T1..T4); back-to-back requests accepted in T4 yield T1 on the following cycle, no TI gap.
REQ-034 RD and WR never low simultaneously; ALE never high outside T1.
REQ-035 rsp_rdata holds last value until next read completion.

Reset
REQ-036 RESET=1 on an edge forces TI regardless of current state, aborting any cycle in progress without rsp_valid.
REQ-037 Reset values: ALE=0, RD=1, WR=1, IOM=0, Address=0, Data high-Z, req_ready=0 during reset, rsp_valid=0, rsp_err=0, rsp_rdata=0, wait counter=0.
REQ-038 First request accepted no earlier than the first edge after RESET deasserts.

Structure
REQ-039 Shared package i8088_pkg holds the bus-state enum, cycle-type enum (READ/WRITE), and default widths ADDR_W/DATA_W.
REQ-040 Wait-state counter and timeout compare implemented in sub-module i8088_wait_timer (clear, enable, timeout out).
REQ-041 Data tri-state driven by a single continuous assignment gated by a registered drive-enable.

Verification
REQ-042 Read 0x12345, memory, READY=1, peripheral returns 0xA5 in T3 -> ALE high one cycle, RD low 2 cycles, rsp_valid 4 cycles after acceptance, rsp_rdata=0xA5, rsp_err=0.
REQ-043 Write 0x0FFFF, data 0x3C, IO space -> IOM=0, WR low T2-T3, Data=0x3C T2-T4, high-Z otherwise, rsp_valid once.
REQ-044 Read with READY low 3 cycles -> exactly 3 TW, data sampled on READY-high edge, 7-cycle transaction.
REQ-045 READY held low, MAX_WAIT=15 -> 15 TW then T4, rsp_err=1, rsp_rdata=0x00, strobes released.
REQ-046 req_valid held high for write then read -> second T1 immediately after first T4, no RD/WR overlap.
REQ-047 RESET asserted during TW of a write -> next cycle TI, WR=1, Data high-Z, no rsp_valid.

Source files
------------

// File: rtl/i8088_pkg.sv
// Shared types for the 8088-style bus master: bus-state encoding, cycle type, default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package i8088_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 8;

  // Wide enough for the largest supported wait-state limit (255).
  localparam int WAIT_CNT_W = 8;

  // One-hot bus states, named after the classic 8088 T-states.
  typedef enum logic [5:0] {
    TI = 6'b000001,
    T1 = 6'b000010,
    T2 = 6'b000100,
    T3 = 6'b001000,
    TW = 6'b010000,
    T4 = 6'b100000
  } bus_state_e;

  typedef enum logic {
    CYC_READ  = 1'b0,
    CYC_WRITE = 1'b1
  } cyc_type_e;

endpackage

// File: rtl/i8088_wait_timer.sv
// Wait-state counter with timeout compare for the bus master.
// Latency: timeout is combinational from the registered count and enable.
// Backpressure: none; the owner decides when to clear and when to count.
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clear     - zero the count (issued on the T3 -> TW transition)
//   enable    - count one wait state this cycle (high while in TW)
//   timeout   - this TW cycle is the MAX_WAIT-th one
module i8088_wait_timer
  import i8088_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam logic [WAIT_CNT_W-1:0] LAST = WAIT_CNT_W'(MAX_WAIT - 1);

  logic [WAIT_CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + WAIT_CNT_W'(1);
    end
  end

  // The count holds the number of TW cycles already completed, so the
  // MAX_WAIT-th TW cycle sees MAX_WAIT-1; the count reaches MAX_WAIT on its
  // closing edge, which is when the cycle is abandoned.
  assign timeout = enable && (count == LAST);

endmodule

// File: rtl/i8088_bus_master.sv
// 8088-style bus master: turns host requests into T1..T4 bus cycles with READY wait states.
// Latency: response in the 4th cycle after acceptance, plus one cycle per wait state.
// Backpressure: req_ready only in TI/T4; READY low stretches the cycle up to MAX_WAIT, then aborts.
//
// Ports:
//   CLK, RESET                     - clock, synchronous active-high reset
//   req_valid/req_ready            - request handshake; req_write, req_iom, req_addr, req_wdata
//   rsp_valid, rsp_rdata, rsp_err  - one-cycle completion pulse with read data / timeout flag
//   ALE, RD, WR, IOM, Address      - bus control (RD/WR active-low) and address
//   Data                           - bidirectional data bus, high-Z unless writing
//   READY                          - peripheral ready, low inserts wait states
module i8088_bus_master
  import i8088_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_iom,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ALE,
  output logic              RD,
  output logic              WR,
  output logic              IOM,
  output logic [ADDR_W-1:0] Address,
  inout  wire  [DATA_W-1:0] Data,
  input  logic              READY
);

  bus_state_e state;
  bus_state_e state_nxt;

  // Request latched at acceptance; held for the whole bus cycle.
  cyc_type_e         cyc_type;
  logic              iom_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] rdata_q;
  logic              abort_q;
  logic              drive_en;

  logic accept;
  logic timer_clear;
  logic timer_en;
  logic timeout;
  logic capture;
  logic abort_set;
  logic strobe_phase;

  i8088_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (CLK),
    .rst     (RESET),
    .clear   (timer_clear),
    .enable  (timer_en),
    .timeout (timeout)
  );

  // Gated by RESET so no request can slip in on a reset edge.
  assign req_ready = !RESET && ((state == TI) || (state == T4));
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nxt   = state;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    capture     = 1'b0;
    abort_set   = 1'b0;
    unique case (state)
      TI, T4: begin
        state_nxt = accept ? T1 : TI;
      end
      T1: begin
        state_nxt = T2;
      end
      T2: begin
        state_nxt = T3;
      end
      T3: begin
        if (READY) begin
          state_nxt = T4;
          capture   = 1'b1;
        end else begin
          state_nxt   = TW;
          timer_clear = 1'b1;
        end
      end
      TW: begin
        timer_en = 1'b1;
        // A peripheral that answers on the last allowed wait state still wins.
        if (READY) begin
          state_nxt = T4;
          capture   = 1'b1;
        end else if (timeout) begin
          state_nxt = T4;
          abort_set = 1'b1;
        end
      end
      default: begin
        state_nxt = TI;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= TI;
      cyc_type <= CYC_READ;
      iom_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      abort_q  <= 1'b0;
      drive_en <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cyc_type <= req_write ? CYC_WRITE : CYC_READ;
        iom_q    <= req_iom;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        abort_q  <= 1'b0;
      end
      if (capture && (cyc_type == CYC_READ)) begin
        rdata_q <= Data;
      end
      if (abort_set) begin
        abort_q <= 1'b1;
        // An aborted read completes with zero data rather than stale bus contents.
        if (cyc_type == CYC_READ) begin
          rdata_q <= '0;
        end
      end
      // Registered from the next state so the bus is driven exactly T2..T4.
      drive_en <= (cyc_type == CYC_WRITE) &&
                  ((state_nxt == T2) || (state_nxt == T3) ||
                   (state_nxt == TW) || (state_nxt == T4));
    end
  end

  assign strobe_phase = (state == T2) || (state == T3) || (state == TW);

  assign ALE       = (state == T1);
  assign RD        = !(strobe_phase && (cyc_type == CYC_READ));
  assign WR        = !(strobe_phase && (cyc_type == CYC_WRITE));
  assign IOM       = iom_q;
  assign Address   = addr_q;
  assign rsp_valid = (state == T4);
  assign rsp_err   = rsp_valid && abort_q;
  // Writes complete with zero data; otherwise the last read result persists.
  assign rsp_rdata = (rsp_valid && (cyc_type == CYC_WRITE)) ? '0 : rdata_q;

  assign Data = drive_en ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_i8088_bus_master.sv
module tb_i8088_bus_master;

  localparam int AW = 20;
  localparam int DW = 8;
  localparam int MW = 15;

  logic          CLK       = 1'b0;
  logic          RESET     = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic          req_iom   = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          READY     = 1'b1;
  wire           req_ready, rsp_valid, rsp_err, ALE, RD, WR, IOM;
  wire  [DW-1:0] rsp_rdata;
  wire  [AW-1:0] Address;
  wire  [DW-1:0] Data;
  logic          tb_drv = 1'b0;
  logic [DW-1:0] tb_dat = '0;

  assign Data = tb_drv ? tb_dat : {DW{1'bz}};

  always #5 CLK = ~CLK;

  i8088_bus_master #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_iom(req_iom),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ALE(ALE), .RD(RD), .WR(WR), .IOM(IOM), .Address(Address), .Data(Data), .READY(READY)
  );

  // One expected bus cycle (one clock) of the reference timeline.
  typedef struct packed {
    logic ale, rd_n, wr_n, drv, last, err, rdy, wt, is_write, rst_tw;
    logic [1:0] cap;            // 1: read data lands, 2: read result forced to zero
    logic [DW-1:0] wdata, rdata;
  } ent_t;

  typedef struct packed {
    logic write, iom, rst_tw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata;
    logic [7:0] d;              // READY-low samples before READY rises
    logic [7:0] gap;            // idle cycles before this request is offered
  } req_t;

  ent_t q[$];
  req_t stim[$];
  req_t preq;
  logic pend = 1'b0;
  logic rnd_rst = 1'b0;
  logic tw_rst_fired = 1'b0;
  logic post_chk = 1'b0;
  logic [DW-1:0] rdata_m = '0;
  logic [AW-1:0] addr_m = '0;
  logic iom_m = 1'b0;
  int cyc = 0, total = 0, bad = 0, rst_cnt = 0, gap_cnt = 0;

  logic mon_on = 1'b0;
  int mon_cyc = 0, mon_rd = 0, mon_wr = 0, mon_ale = 0, ale_cyc = 0, n_rsp = 0;
  int rec_lat[16], rec_rd[16], rec_wr[16], rec_ale[16], rec_alec[16], rec_rspc[16];
  logic [DW-1:0] rec_rdata[16], rec_wdat[16];
  logic rec_err[16], rec_iom[16];
  logic [AW-1:0] rec_addr[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic req_t mk(input logic w, input logic iom, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                              input int d, input int gap, input logic rst_tw);
    req_t r;
    r.write = w; r.iom = iom; r.addr = a; r.wdata = wd; r.rdata = rd;
    r.d = 8'(d); r.gap = 8'(gap); r.rst_tw = rst_tw;
    return r;
  endfunction

  // Expand an accepted request into its clock-by-clock expected bus behaviour:
  // address cycle, strobe cycle, (1 + waits) READY-sampling cycles, completion.
  task automatic push_txn(input req_t r);
    int w, j;
    logic err;
    ent_t e;
    w   = (int'(r.d) > MW) ? MW : int'(r.d);
    err = (int'(r.d) > MW);
    for (int k = 0; k <= 3 + w; k++) begin
      e = '0;
      e.rd_n = 1'b1; e.wr_n = 1'b1;
      e.is_write = r.write; e.wdata = r.wdata; e.rdata = r.rdata;
      e.rdy = 1'($urandom_range(1, 0));
      if (k == 0) begin
        e.ale = 1'b1;
      end else if (k == 3 + w) begin
        e.last = 1'b1; e.err = err; e.drv = r.write;
      end else begin
        e.rd_n = r.write; e.wr_n = !r.write; e.drv = r.write;
        if (k >= 2) begin
          j = k - 2;
          e.wt = (j > 0);
          e.rst_tw = r.rst_tw && (j > 0);
          e.rdy = (j >= int'(r.d));
          if (j == w) e.cap = r.write ? 2'd0 : (err ? 2'd2 : 2'd1);
        end
      end
      q.push_back(e);
    end
  endtask

  task automatic cycle();
    ent_t cur;
    logic exp_rdy, fired_now;
    logic [DW-1:0] dexp, rexp;
    @(negedge CLK);
    cyc++;
    fired_now = 1'b0;
    if (rst_cnt > 0) begin
      RESET = 1'b1; rst_cnt--;
    end else if (q.size() > 0 && q[0].rst_tw) begin
      RESET = 1'b1; tw_rst_fired = 1'b1; fired_now = 1'b1;
    end else if (rnd_rst && $urandom_range(149, 0) == 0) begin
      RESET = 1'b1;
    end else begin
      RESET = 1'b0;
    end
    if (q.size() > 0) cur = q[0];
    else begin
      cur = '0; cur.rd_n = 1'b1; cur.wr_n = 1'b1; cur.rdy = 1'($urandom_range(1, 0));
    end
    READY  = cur.rdy;
    tb_drv = !cur.rd_n;
    tb_dat = cur.rdata;
    if (!pend) begin
      if (gap_cnt > 0) gap_cnt--;
      else if (stim.size() > 0) begin
        preq = stim.pop_front();
        pend = 1'b1;
        gap_cnt = (stim.size() > 0) ? int'(stim[0].gap) : 0;
      end
    end
    req_valid = pend;
    if (pend) begin
      req_write = preq.write; req_iom = preq.iom; req_addr = preq.addr; req_wdata = preq.wdata;
    end else begin
      req_write = 1'($urandom_range(1, 0)); req_iom = 1'($urandom_range(1, 0));
      req_addr = AW'($urandom); req_wdata = DW'($urandom);
    end
    #1;
    exp_rdy = !RESET && (q.size() == 0 || q[0].last);
    dexp = cur.drv ? cur.wdata : (tb_drv ? tb_dat : {DW{1'bz}});
    rexp = (cur.last && cur.is_write) ? '0 : rdata_m;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("ALE", 32'(ALE), 32'(cur.ale));
    chk("RD", 32'(RD), 32'(cur.rd_n));
    chk("WR", 32'(WR), 32'(cur.wr_n));
    chk("rd_wr_overlap", 32'(RD | WR), 32'd1);
    chk("IOM", 32'(IOM), 32'(iom_m));
    chk("Address", 32'(Address), 32'(addr_m));
    chk("Data", {24'h0, Data}, {24'h0, dexp});
    chk("rsp_valid", 32'(rsp_valid), 32'(cur.last));
    chk("rsp_err", 32'(rsp_err), 32'(cur.last && cur.err));
    chk("rsp_rdata", {24'h0, rsp_rdata}, {24'h0, rexp});
    if (post_chk) begin
      post_chk = 1'b0;
      chk("post_rst_WR", 32'(WR), 32'd1);
      chk("post_rst_Data", {24'h0, Data}, {24'h0, 8'hzz});
      chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_rst_ALE", 32'(ALE), 32'd0);
    end
    // Direct measurements of bus activity per transaction, for literal checks.
    if (mon_on) begin
      mon_cyc++;
      if (RD === 1'b0) mon_rd++;
      if (WR === 1'b0) mon_wr++;
      if (ALE === 1'b1) mon_ale++;
    end
    if (ALE === 1'b1) ale_cyc = cyc;
    if (rsp_valid === 1'b1) begin
      if (n_rsp < 16) begin
        rec_lat[n_rsp] = mon_cyc; rec_rd[n_rsp] = mon_rd; rec_wr[n_rsp] = mon_wr;
        rec_ale[n_rsp] = mon_ale; rec_alec[n_rsp] = ale_cyc; rec_rspc[n_rsp] = cyc;
        rec_rdata[n_rsp] = rsp_rdata; rec_err[n_rsp] = rsp_err; rec_iom[n_rsp] = IOM;
        rec_addr[n_rsp] = Address; rec_wdat[n_rsp] = Data;
      end
      n_rsp++;
      mon_on = 1'b0;
    end
    @(posedge CLK);
    if (RESET) begin
      q.delete();
      rdata_m = '0; addr_m = '0; iom_m = 1'b0; mon_on = 1'b0;
      if (fired_now) post_chk = 1'b1;
    end else begin
      if (q.size() > 0) begin
        if (q[0].cap == 2'd1) rdata_m = q[0].rdata;
        else if (q[0].cap == 2'd2) rdata_m = '0;
        void'(q.pop_front());
      end
      if (pend && exp_rdy) begin
        push_txn(preq);
        addr_m = preq.addr; iom_m = preq.iom; pend = 1'b0;
        mon_on = 1'b1; mon_cyc = 0; mon_rd = 0; mon_wr = 0; mon_ale = 0;
      end
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((stim.size() > 0 || pend || q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    for (int i = 0; i < 3; i++) cycle();
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL run_budget cycles=%0d want below %0d", n, budget);
    end
  endtask

  initial begin
    int dd, gg;
    rst_cnt = 3;
    // Directed sequence: plain read, I/O write, 3 wait states, timeout,
    // back-to-back write->read, then a write reset in the middle of its waits.
    stim.push_back(mk(1'b0, 1'b1, 20'h12345, 8'h00, 8'hA5, 0, 0, 1'b0));
    stim.push_back(mk(1'b1, 1'b0, 20'h0FFFF, 8'h3C, 8'h00, 0, 2, 1'b0));
    stim.push_back(mk(1'b0, 1'b1, 20'h00400, 8'h00, 8'h5A, 3, 2, 1'b0));
    stim.push_back(mk(1'b0, 1'b1, 20'h80001, 8'h00, 8'h77, 20, 2, 1'b0));
    stim.push_back(mk(1'b1, 1'b1, 20'h00010, 8'hC3, 8'h00, 0, 2, 1'b0));
    stim.push_back(mk(1'b0, 1'b1, 20'h00011, 8'h00, 8'h96, 0, 0, 1'b0));
    stim.push_back(mk(1'b1, 1'b1, 20'h2AAAA, 8'h5F, 8'h00, 10, 2, 1'b1));
    run_until_idle(2000);

    chk("dir_rsp_count", n_rsp, 6);
    chk("dir_tw_reset_applied", 32'(tw_rst_fired), 32'd1);
    chk("rd0_latency", rec_lat[0], 4);
    chk("rd0_ale_cycles", rec_ale[0], 1);
    chk("rd0_rd_low", rec_rd[0], 2);
    chk("rd0_rdata", 32'(rec_rdata[0]), 32'hA5);
    chk("rd0_err", 32'(rec_err[0]), 32'd0);
    chk("rd0_addr", 32'(rec_addr[0]), 32'h12345);
    chk("rd0_iom", 32'(rec_iom[0]), 32'd1);
    chk("wr1_latency", rec_lat[1], 4);
    chk("wr1_wr_low", rec_wr[1], 2);
    chk("wr1_rd_low", rec_rd[1], 0);
    chk("wr1_iom", 32'(rec_iom[1]), 32'd0);
    chk("wr1_data_t4", 32'(rec_wdat[1]), 32'h3C);
    chk("wr1_addr", 32'(rec_addr[1]), 32'h0FFFF);
    chk("rd2_latency", rec_lat[2], 7);
    chk("rd2_rd_low", rec_rd[2], 5);
    chk("rd2_rdata", 32'(rec_rdata[2]), 32'h5A);
    chk("to3_latency", rec_lat[3], 19);
    chk("to3_rd_low", rec_rd[3], 17);
    chk("to3_err", 32'(rec_err[3]), 32'd1);
    chk("to3_rdata", 32'(rec_rdata[3]), 32'h00);
    chk("b2b_wr_latency", rec_lat[4], 4);
    chk("b2b_rd_latency", rec_lat[5], 4);
    chk("b2b_no_idle_gap", rec_alec[5] - rec_rspc[4], 1);
    chk("b2b_rdata", 32'(rec_rdata[5]), 32'h96);

    // Randomized traffic with occasional asynchronous-to-traffic resets.
    rnd_rst = 1'b1;
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(9, 0))
        8:       dd = $urandom_range(15, 10);
        9:       dd = $urandom_range(20, 16);
        6, 7:    dd = $urandom_range(4, 1);
        default: dd = 0;
      endcase
      gg = ($urandom_range(3, 0) == 0) ? $urandom_range(4, 1) : 0;
      stim.push_back(mk(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), AW'($urandom),
                        DW'($urandom), DW'($urandom), dd, gg, 1'b0));
    end
    run_until_idle(40000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
